// File: rtl/irq_request_capture_if.sv
// Bundles the request, mask and acknowledge inputs with the pending, presentation and loss outputs.
// Ports: master drives req_in/mask/ack/clear_all; slave (the capture block) drives the rest.
// Signal widths are fixed at 16 request lines and a 4-bit request index.
interface irq_request_capture_if #(
    parameter int NREQ = 16,
    parameter int IDW  = 4
);
    logic [NREQ-1:0] req_in;
    logic [NREQ-1:0] mask;
    logic            ack;
    logic            clear_all;
    logic [NREQ-1:0] pend;
    logic            irq_valid;
    logic [IDW-1:0]  irq_id;
    logic            overflow;
    logic [7:0]      lost_count;

    modport master (
        output req_in, mask, ack, clear_all,
        input  pend, irq_valid, irq_id, overflow, lost_count
    );

    modport slave (
        input  req_in, mask, ack, clear_all,
        output pend, irq_valid, irq_id, overflow, lost_count
    );
endinterface

// File: rtl/irq_request_capture.sv
// Captures rising edges on 16 request lines into a pending vector and presents the highest-priority unmasked one.
// Latency: rise before edge k -> pend after edge k -> irq_valid after edge k+1 (from IDLE); every output is registered.
// Backpressure: a presented request holds until acked or masked; a re-rise on a still-pending bit is lost and counted.
// Ports: clk, rst (sync, active-high); bus.req_in/mask/ack/clear_all in; bus.pend/irq_valid/irq_id/overflow/lost_count out.
module irq_request_capture #(
    parameter int NREQ = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    irq_request_capture_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_BUBBLE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] req_prev_q, req_prev_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic            irq_valid_q, irq_valid_d;
    logic [IDW-1:0]  irq_id_q, irq_id_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      lost_count_q, lost_count_d;

    logic [NREQ-1:0] rise;
    logic [NREQ-1:0] clr;
    logic [NREQ-1:0] cand;
    logic [IDW-1:0]  winner;
    logic            ack_acc;
    logic            lost_hit;

    // Edge detect, acknowledge qualification and priority pick.
    always_comb begin
        rise    = bus.req_in & ~req_prev_q;
        // An ack only counts while something is actually being presented.
        ack_acc = bus.ack && (state_q == ST_PRESENT);
        clr     = ack_acc ? (NREQ'(1) << irq_id_q) : '0;
        cand    = pend_q & ~bus.mask;
        winner  = '0;
        // Ascending scan: the last hit is the highest index, which has priority.
        for (int i = 0; i < NREQ; i++) begin
            if (cand[i]) begin
                winner = IDW'(i);
            end
        end
        // A rise on the bit being cleared this cycle is a fresh capture, not a loss.
        lost_hit = |(rise & pend_q & ~clr);
    end

    // Pending vector and loss accounting.
    always_comb begin
        req_prev_d   = bus.req_in;
        pend_d       = (pend_q & ~clr) | rise;  // set wins over a same-cycle clear
        overflow_d   = lost_hit;
        lost_count_d = lost_count_q;
        if (lost_hit && (lost_count_q != 8'hFF)) begin
            lost_count_d = lost_count_q + 8'd1;
        end
        if (bus.clear_all) begin
            pend_d       = '0;
            overflow_d   = 1'b0;
            lost_count_d = lost_count_q;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        if (bus.clear_all) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|cand) begin
                        state_d = ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // Ack takes precedence over a withdrawal by masking.
                    if (bus.ack) begin
                        state_d = ST_BUBBLE;
                    end else if (bus.mask[irq_id_q]) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUBBLE: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: irq_id is loaded only on the IDLE->PRESENT transition so it stays frozen while presented.
    always_comb begin
        irq_valid_d = (state_d == ST_PRESENT);
        irq_id_d    = irq_id_q;
        if ((state_q == ST_IDLE) && (state_d == ST_PRESENT)) begin
            irq_id_d = winner;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_prev_q   <= '0;
            pend_q       <= '0;
            irq_valid_q  <= 1'b0;
            irq_id_q     <= '0;
            overflow_q   <= 1'b0;
            lost_count_q <= '0;
        end else begin
            state_q      <= state_d;
            req_prev_q   <= req_prev_d;
            pend_q       <= pend_d;
            irq_valid_q  <= irq_valid_d;
            irq_id_q     <= irq_id_d;
            overflow_q   <= overflow_d;
            lost_count_q <= lost_count_d;
        end
    end

    assign bus.pend       = pend_q;
    assign bus.irq_valid  = irq_valid_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.overflow   = overflow_q;
    assign bus.lost_count = lost_count_q;
endmodule

// File: tb/tb_irq_request_capture.sv
module tb_irq_request_capture;
    logic clk;
    logic rst;

    irq_request_capture_if bus ();

    irq_request_capture #(.NREQ(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] pend;
        logic        valid;
        logic [3:0]  id;
        logic        ovf;
        logic [7:0]  lost;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: pending set as a bit array, presentation as "which index is shown" (-1 = none).
    bit [15:0] m_pend;
    bit [15:0] m_prev;
    int        m_pres = -1;
    bit        m_bub;
    int        m_id;
    bit        m_ovf;
    int        m_lost;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        int   acked;
        int   win;
        bit   lost;
        exp_t e;
        if (rst) begin
            m_pend = '0; m_prev = '0; m_pres = -1; m_bub = 0;
            m_id = 0; m_ovf = 0; m_lost = 0;
        end else if (bus.clear_all) begin
            m_pend = '0; m_pres = -1; m_bub = 0; m_ovf = 0;
            m_prev = bus.req_in;
        end else begin
            acked = (m_pres >= 0 && bus.ack) ? m_pres : -1;
            win = -1;
            for (int i = 0; i < 16; i++) begin
                if (m_pend[i] && !bus.mask[i]) win = i;
            end
            if (acked >= 0) begin
                m_pres = -1;
                m_bub  = 1;
            end else if (m_pres >= 0) begin
                if (bus.mask[m_pres]) m_pres = -1;
            end else if (m_bub) begin
                m_bub = 0;
            end else if (win >= 0) begin
                m_pres = win;
                m_id   = win;
            end
            lost = 0;
            for (int i = 0; i < 16; i++) begin
                if (bus.req_in[i] && !m_prev[i]) begin
                    if (m_pend[i] && i != acked) lost = 1;
                    m_pend[i] = 1'b1;
                end else if (i == acked) begin
                    m_pend[i] = 1'b0;
                end
            end
            m_ovf = lost;
            if (lost && m_lost < 255) m_lost++;
            m_prev = bus.req_in;
        end
        e.pend  = m_pend;
        e.valid = (m_pres >= 0);
        e.id    = 4'(m_id);
        e.ovf   = m_ovf;
        e.lost  = 8'(m_lost);
        exp_q.push_back(e);
    endtask

    // Model advances on every edge with the inputs the DUT samples.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compares each registered output set against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_pend",       bus.pend,       e.pend);
                chk("sb_irq_valid",  bus.irq_valid,  e.valid);
                chk("sb_irq_id",     bus.irq_id,     e.id);
                chk("sb_overflow",   bus.overflow,   e.ovf);
                chk("sb_lost_count", bus.lost_count, e.lost);
            end
        end
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_in = '0; bus.mask = '0; bus.ack = 1'b0; bus.clear_all = 1'b0;
        clk1(); clk1();
        chk("rst_pend", bus.pend, 16'h0);
        chk("rst_valid", bus.irq_valid, 0);
        chk("rst_id", bus.irq_id, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_lost", bus.lost_count, 0);
        rst = 1'b0;

        // Basic capture and ack.
        bus.req_in = 16'h0010; clk1();
        chk("cap_pend", bus.pend, 16'h0010);
        chk("cap_valid_early", bus.irq_valid, 0);
        clk1();
        chk("cap_valid", bus.irq_valid, 1);
        chk("cap_id", bus.irq_id, 4);
        bus.ack = 1'b1; clk1(); bus.ack = 1'b0;
        chk("ack_pend", bus.pend, 16'h0);
        chk("ack_valid", bus.irq_valid, 0);

        // Priority and no pre-emption.
        bus.req_in = 16'h0000; clk1();
        bus.req_in = 16'h0003; clk1(); clk1();
        chk("pri_id1", bus.irq_id, 1);
        bus.req_in = 16'h8003; clk1();
        chk("nopre_pend", bus.pend, 16'h8003);
        chk("nopre_id", bus.irq_id, 1);
        bus.ack = 1'b1; clk1(); bus.ack = 1'b0;
        chk("bubble_valid", bus.irq_valid, 0);
        clk1(); clk1();
        chk("pri_valid15", bus.irq_valid, 1);
        chk("pri_id15", bus.irq_id, 15);
        bus.ack = 1'b1; clk1(); bus.ack = 1'b0;
        clk1(); clk1();
        chk("pri_id0", bus.irq_id, 0);
        bus.ack = 1'b1; clk1(); bus.ack = 1'b0;

        // Mask hides but retains.
        bus.req_in = 16'h0000; clk1();
        bus.req_in = 16'h8001; bus.mask = 16'h8000; clk1();
        chk("mask_pend", bus.pend, 16'h8001);
        clk1();
        chk("mask_id", bus.irq_id, 0);
        chk("mask_valid", bus.irq_valid, 1);
        bus.mask = 16'h8001; clk1();
        chk("withdraw_valid", bus.irq_valid, 0);
        chk("withdraw_pend", bus.pend, 16'h8001);
        bus.clear_all = 1'b1; bus.mask = '0; clk1();
        bus.clear_all = 1'b0; bus.req_in = '0; clk1();

        // Single loss.
        bus.mask = 16'hFFFF; bus.req_in = 16'h0004; clk1();
        chk("loss_pend", bus.pend, 16'h0004);
        bus.req_in = 16'h0000; clk1();
        bus.req_in = 16'h0004; clk1();
        chk("loss_ovf", bus.overflow, 1);
        chk("loss_cnt", bus.lost_count, 1);
        clk1();
        chk("loss_ovf_pulse", bus.overflow, 0);

        // clear_all against a same-cycle rise on a pending bit.
        bus.req_in = 16'hFFFF; clk1();
        chk("full_pend", bus.pend, 16'hFFFF);
        bus.req_in = 16'hFFFE; clk1();
        bus.req_in = 16'hFFFF; bus.clear_all = 1'b1; clk1(); bus.clear_all = 1'b0;
        chk("clr_pend", bus.pend, 16'h0);
        chk("clr_valid", bus.irq_valid, 0);
        chk("clr_ovf", bus.overflow, 0);
        chk("clr_lost", bus.lost_count, 1);
        bus.req_in = '0; clk1();

        // Saturation.
        bus.req_in = 16'h0004; clk1();
        for (int k = 0; k < 300; k++) begin
            bus.req_in = 16'h0000; clk1();
            bus.req_in = 16'h0004; clk1();
        end
        chk("sat_lost", bus.lost_count, 255);
        chk("sat_ovf", bus.overflow, 1);

        // Set wins over a same-cycle ack.
        bus.mask = 16'h0000; clk1();
        chk("sw_valid", bus.irq_valid, 1);
        chk("sw_id", bus.irq_id, 2);
        bus.req_in = 16'h0000; clk1();
        bus.ack = 1'b1; bus.req_in = 16'h0004; clk1(); bus.ack = 1'b0;
        chk("sw_pend", bus.pend, 16'h0004);
        chk("sw_ovf", bus.overflow, 0);
        chk("sw_bubble", bus.irq_valid, 0);
        clk1(); clk1();
        chk("sw_repres", bus.irq_valid, 1);

        // Reset mid-presentation with a line held high through it.
        rst = 1'b1; bus.req_in = 16'h0001; clk1();
        chk("mrst_pend", bus.pend, 16'h0);
        chk("mrst_valid", bus.irq_valid, 0);
        chk("mrst_id", bus.irq_id, 0);
        chk("mrst_lost", bus.lost_count, 0);
        rst = 1'b0; clk1();
        chk("post_rst_pend", bus.pend, 16'h0001);

        // Randomised traffic, including acks while nothing is presented.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req_in = bus.req_in ^ (16'(1) << $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) bus.mask = 16'($urandom) & 16'($urandom);
            bus.ack       = ($urandom_range(0, 2) == 0);
            bus.clear_all = ($urandom_range(0, 99) == 0);
            rst           = ($urandom_range(0, 499) == 0);
            clk1();
        end
        rst = 1'b0; bus.ack = 1'b0; bus.clear_all = 1'b0;
        clk1(); clk1();
        @(negedge clk); #1;
        chk("sb_drain", 16'(exp_q.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
